// File: rtl/gpio_intr_engine_if.sv
// Pin, control and status bundle between the GPIO interrupt engine and the
// register block / interrupt aggregator that drives and observes it.
interface gpio_intr_engine_if #(
  parameter int NUM_GPIO    = 256,
  parameter int GROUP_WIDTH = 32,
  parameter int DEBOUNCE_W  = 8
);
  localparam int NUM_GROUPS = NUM_GPIO / GROUP_WIDTH;

  logic [NUM_GPIO-1:0]   gpio_in_data;
  logic [NUM_GPIO-1:0]   intr_enable;
  logic [3*NUM_GPIO-1:0] intr_mode;
  logic [DEBOUNCE_W-1:0] debounce_limit;
  logic [NUM_GPIO-1:0]   status_clr;
  logic [NUM_GPIO-1:0]   intr_status;
  logic [NUM_GROUPS-1:0] group_intr;

  // The register block side owns configuration and clears and watches status.
  modport master (
    output gpio_in_data,
    output intr_enable,
    output intr_mode,
    output debounce_limit,
    output status_clr,
    input  intr_status,
    input  group_intr
  );

  modport slave (
    input  gpio_in_data,
    input  intr_enable,
    input  intr_mode,
    input  debounce_limit,
    input  status_clr,
    output intr_status,
    output group_intr
  );
endinterface

// File: rtl/gpio_intr_engine.sv
// Parametrised GPIO interrupt engine: synchronise, optionally debounce, detect per-pin
// events, latch W1C status and raise one summary interrupt per group. Debounce: GPIO_INTR_DEBOUNCE_EN.
module gpio_intr_engine #(
  parameter int NUM_GPIO    = 256,
  parameter int GROUP_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  gpio_intr_engine_if.slave bus
);
  localparam int NUM_GROUPS = NUM_GPIO / GROUP_WIDTH;

  localparam logic [2:0] MODE_RISE = 3'd0;
  localparam logic [2:0] MODE_FALL = 3'd1;
  localparam logic [2:0] MODE_BOTH = 3'd2;
  localparam logic [2:0] MODE_HIGH = 3'd3;
  localparam logic [2:0] MODE_LOW  = 3'd4;

  logic [NUM_GPIO-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0]   sync_d [SYNC_STAGES];
  logic [NUM_GPIO-1:0]   sync;
  logic [NUM_GPIO-1:0]   filt;
  logic [NUM_GPIO-1:0]   prev_q, prev_d;
  logic [NUM_GPIO-1:0]   rise, fall, evt;
  logic [NUM_GPIO-1:0]   status_q, status_d;
  logic [NUM_GROUPS-1:0] group_q, group_d;

  always_comb begin
    sync_d[0] = bus.gpio_in_data;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_INTR_DEBOUNCE_EN
  logic [NUM_GPIO-1:0]   filt_q, filt_d;
  logic [DEBOUNCE_W-1:0] cnt_q [NUM_GPIO];
  logic [DEBOUNCE_W-1:0] cnt_d [NUM_GPIO];

  // A pin must disagree with filt for limit+1 consecutive cycles before filt follows;
  // >= keeps a lowered limit from letting an in-flight count run past it and wrap.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_GPIO; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != filt_q[i]) begin
        if (cnt_q[i] >= bus.debounce_limit) begin
          filt_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  logic [DEBOUNCE_W-1:0] debounce_limit_unused;

  assign debounce_limit_unused = bus.debounce_limit;
  assign filt = sync;
`endif

  assign prev_d = filt;
  assign rise   = filt & ~prev_q;
  assign fall   = ~filt & prev_q;

  always_comb begin
    evt = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      case (bus.intr_mode[3*i +: 3])
        MODE_RISE: evt[i] = rise[i];
        MODE_FALL: evt[i] = fall[i];
        MODE_BOTH: evt[i] = rise[i] | fall[i];
        MODE_HIGH: evt[i] = filt[i];
        MODE_LOW:  evt[i] = ~filt[i];
        default:   evt[i] = 1'b0;
      endcase
    end
  end

  // A new set beats a same-cycle clear, so level modes stay latched while the level holds.
  always_comb begin
    status_d = (status_q & ~bus.status_clr) | (evt & bus.intr_enable);
    group_d  = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      group_d[g] = |status_q[g*GROUP_WIDTH +: GROUP_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      status_q <= '0;
      group_q  <= '0;
    end else begin
      prev_q   <= prev_d;
      status_q <= status_d;
      group_q  <= group_d;
    end
  end

  assign bus.intr_status = status_q;
  assign bus.group_intr  = group_q;

endmodule

// File: tb/tb_gpio_intr_engine.sv
// Self-checking bench for gpio_intr_engine: a vector table of per-pin mode cases plus
// hand-written multi-cycle sequences, all checked through a cycle-stamped scoreboard.
module tb_gpio_intr_engine;
  localparam int NUM_GPIO    = 256;
  localparam int GROUP_WIDTH = 32;
  localparam int NUM_GROUPS  = NUM_GPIO / GROUP_WIDTH;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE_W  = 8;

  localparam logic [2:0] M_RISE = 3'd0;
  localparam logic [2:0] M_FALL = 3'd1;
  localparam logic [2:0] M_BOTH = 3'd2;
  localparam logic [2:0] M_HIGH = 3'd3;
  localparam logic [2:0] M_LOW  = 3'd4;
  localparam logic [2:0] M_NONE = 3'd7;

  logic clk;
  logic rst_n;

  gpio_intr_engine_if #(
    .NUM_GPIO(NUM_GPIO), .GROUP_WIDTH(GROUP_WIDTH), .DEBOUNCE_W(DEBOUNCE_W)
  ) bus ();

  gpio_intr_engine #(
    .NUM_GPIO(NUM_GPIO), .GROUP_WIDTH(GROUP_WIDTH),
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                    due;
    string                 name;
    logic [NUM_GPIO-1:0]   st;
    logic [NUM_GROUPS-1:0] grp;
  } sb_item_t;

  typedef struct {
    int         pin;
    logic [2:0] mode;
    logic       en;
    logic       lvl0;
    logic       lvl1;
    logic       pre;
    logic       post;
  } vec_t;

  sb_item_t sb_q[$];
  vec_t     vecs[$];
  int       checks   = 0;
  int       failures = 0;
  int       cycle    = 0;
  int       db_limit = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latency();
`ifdef GPIO_INTR_DEBOUNCE_EN
    return SYNC_STAGES + db_limit + 1;
`else
    return SYNC_STAGES;
`endif
  endfunction

  function automatic logic [NUM_GPIO-1:0] pin_vec(input int p, input logic b);
    logic [NUM_GPIO-1:0] v;
    v    = '0;
    v[p] = b;
    return v;
  endfunction

  function automatic logic [NUM_GROUPS-1:0] grp_vec(input int p, input logic b);
    logic [NUM_GROUPS-1:0] v;
    v                  = '0;
    v[p / GROUP_WIDTH] = b;
    return v;
  endfunction

  task automatic compare(input string name, input logic [NUM_GPIO-1:0] st,
                         input logic [NUM_GROUPS-1:0] grp);
    checks++;
    if (bus.intr_status !== st || bus.group_intr !== grp) begin
      failures++;
      $display("[TB] FAIL %s @cycle %0d: got status=%h group=%h, want status=%h group=%h",
               name, cycle, bus.intr_status, bus.group_intr, st, grp);
    end
  endtask

  // Scoreboard entries fall due a fixed number of clock edges after they are queued.
  task automatic check_output();
    int i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cycle) begin
        compare(sb_q[i].name, sb_q[i].st, sb_q[i].grp);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic expect_after(input int d, input string name,
                              input logic [NUM_GPIO-1:0] st, input logic [NUM_GROUPS-1:0] grp);
    sb_item_t it;
    it.due  = cycle + d;
    it.name = name;
    it.st   = st;
    it.grp  = grp;
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    check_output();
  endtask

  task automatic quiesce();
    bus.intr_enable  = '0;
    bus.intr_mode    = {NUM_GPIO{M_NONE}};
    bus.gpio_in_data = '0;
    bus.status_clr   = '0;
  endtask

  task automatic configure(input int p, input logic [2:0] m, input logic en, input logic lvl);
    bus.intr_mode[3*p +: 3] = m;
    bus.intr_enable[p]      = en;
    bus.gpio_in_data[p]     = lvl;
  endtask

  task automatic clear_all();
    bus.status_clr = '1;
    step();
    bus.status_clr = '0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int lat;
    quiesce();
    configure(v.pin, v.mode, v.en, v.lvl0);
    repeat (6 + db_limit) step();
    bus.status_clr = '1;
    step();
    bus.status_clr = '0;
    expect_after(1, $sformatf("vec%0d_pre", idx), pin_vec(v.pin, v.pre), grp_vec(v.pin, v.pre));
    step();
    lat = latency();
    bus.gpio_in_data[v.pin] = v.lvl1;
    expect_after(lat,     $sformatf("vec%0d_hold", idx),
                 pin_vec(v.pin, v.pre),  grp_vec(v.pin, v.pre));
    expect_after(lat + 1, $sformatf("vec%0d_status", idx),
                 pin_vec(v.pin, v.post), grp_vec(v.pin, v.pre));
    expect_after(lat + 2, $sformatf("vec%0d_group", idx),
                 pin_vec(v.pin, v.post), grp_vec(v.pin, v.post));
    repeat (lat + 2) step();
  endtask

  task automatic seq_same_cycle_and_disable();
    int lat;
    quiesce();
    configure(0, M_RISE, 1'b1, 1'b0);
    repeat (6 + db_limit) step();
    clear_all();
    step();
    lat = latency();
    bus.gpio_in_data[0] = 1'b1;
    repeat (lat) step();
    bus.status_clr[0] = 1'b1;
    expect_after(1, "same_cycle_set_wins", pin_vec(0, 1'b1), '0);
    step();
    bus.status_clr[0] = 1'b0;
    expect_after(1, "same_cycle_group", pin_vec(0, 1'b1), grp_vec(0, 1'b1));
    step();

    bus.intr_mode[2:0] = 3'd5;
    expect_after(3, "mode_change_keeps", pin_vec(0, 1'b1), grp_vec(0, 1'b1));
    repeat (3) step();
    bus.intr_enable[0] = 1'b0;
    expect_after(2, "disable_keeps", pin_vec(0, 1'b1), grp_vec(0, 1'b1));
    repeat (2) step();
    bus.status_clr[0] = 1'b1;
    expect_after(1, "disabled_clr_status", '0, grp_vec(0, 1'b1));
    step();
    bus.status_clr[0] = 1'b0;
    expect_after(1, "disabled_clr_group", '0, '0);
    step();
    bus.intr_mode[2:0]  = M_RISE;
    bus.gpio_in_data[0] = 1'b0;
    repeat (6) step();
    bus.gpio_in_data[0] = 1'b1;
    expect_after(lat + 3, "disabled_no_reset", '0, '0);
    repeat (lat + 3) step();
  endtask

  task automatic seq_level_low();
    int lat;
    lat = latency();
    quiesce();
    configure(63, M_LOW, 1'b1, 1'b0);
    repeat (6 + db_limit) step();
    bus.status_clr[63] = 1'b1;
    expect_after(1, "lvl_low_clr_blocked", pin_vec(63, 1'b1), grp_vec(63, 1'b1));
    step();
    bus.status_clr[63] = 1'b0;
    expect_after(1, "lvl_low_after_clr", pin_vec(63, 1'b1), grp_vec(63, 1'b1));
    step();
    bus.gpio_in_data[63] = 1'b1;
    expect_after(lat + 2, "lvl_low_sticky", pin_vec(63, 1'b1), grp_vec(63, 1'b1));
    repeat (lat + 2) step();
    bus.status_clr[63] = 1'b1;
    expect_after(1, "lvl_low_clr_status", '0, grp_vec(63, 1'b1));
    step();
    bus.status_clr[63] = 1'b0;
    expect_after(1, "lvl_low_clr_group", '0, '0);
    step();
  endtask

`ifdef GPIO_INTR_DEBOUNCE_EN
  task automatic seq_debounce();
    db_limit           = 3;
    bus.debounce_limit = 8'd3;
    quiesce();
    configure(5, M_RISE, 1'b1, 1'b0);
    repeat (12) step();
    clear_all();
    step();
    bus.gpio_in_data[5] = 1'b1;
    repeat (3) step();
    bus.gpio_in_data[5] = 1'b0;
    expect_after(12, "db_glitch_rejected", '0, '0);
    repeat (12) step();
    bus.gpio_in_data[5] = 1'b1;
    expect_after(SYNC_STAGES + 4, "db_not_yet", '0, '0);
    expect_after(SYNC_STAGES + 5, "db_status", pin_vec(5, 1'b1), '0);
    expect_after(SYNC_STAGES + 6, "db_group", pin_vec(5, 1'b1), grp_vec(5, 1'b1));
    repeat (4) step();
    bus.gpio_in_data[5] = 1'b0;
    repeat (SYNC_STAGES + 2) step();
    db_limit           = 0;
    bus.debounce_limit = '0;
    repeat (8) step();
  endtask
`endif

  task automatic seq_reset();
    logic [NUM_GPIO-1:0]   st;
    logic [NUM_GROUPS-1:0] grp;
    int                    lat;
    st  = pin_vec(5, 1'b1) | pin_vec(40, 1'b1) | pin_vec(200, 1'b1);
    grp = grp_vec(5, 1'b1) | grp_vec(40, 1'b1) | grp_vec(200, 1'b1);
    quiesce();
    configure(5,   M_HIGH, 1'b1, 1'b1);
    configure(40,  M_HIGH, 1'b1, 1'b1);
    configure(200, M_HIGH, 1'b1, 1'b1);
    repeat (6 + db_limit) step();
    expect_after(1, "pre_reset", st, grp);
    step();
    #2 rst_n = 1'b0;
    #1 compare("async_reset", '0, '0);
    bus.intr_mode[3*5   +: 3] = M_RISE;
    bus.intr_mode[3*40  +: 3] = M_RISE;
    bus.intr_mode[3*200 +: 3] = M_RISE;
    #2 rst_n = 1'b1;
    lat = latency();
    expect_after(lat,     "release_not_yet", '0, '0);
    expect_after(lat + 1, "release_rise_status", st, '0);
    expect_after(lat + 2, "release_rise_group", st, grp);
    repeat (lat + 2) step();
  endtask

  initial begin
    rst_n = 1'b0;
    quiesce();
    bus.debounce_limit = '0;

    vecs.push_back('{5,   M_RISE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{5,   M_RISE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{40,  M_FALL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{40,  M_FALL, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{40,  M_BOTH, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{41,  M_BOTH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{63,  M_HIGH, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{63,  M_HIGH, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{63,  M_LOW,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{63,  M_LOW,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{100, 3'd5,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{100, 3'd7,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{200, M_RISE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{255, M_RISE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{0,   M_LOW,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{224, M_FALL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{31,  M_HIGH, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});

    @(posedge clk);
    #1 compare("reset_state", '0, '0);
    #2 rst_n = 1'b1;
    expect_after(3, "post_reset_idle", '0, '0);
    repeat (3) step();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], i);
    end

    seq_same_cycle_and_disable();
    seq_level_low();
`ifdef GPIO_INTR_DEBOUNCE_EN
    seq_debounce();
`endif
    seq_reset();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations never compared, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
